// File: rtl/m_ext_ctrl_if.sv
// m_ext_ctrl_if: request, m_ext operand/result and response signals of the m_ext sequencer
interface m_ext_ctrl_if;
  logic ip_req_valid;
  logic op_req_ready;
  logic [31:0] ip_rs1;
  logic [31:0] ip_rs2;
  logic [2:0] ip_funct_3;
  logic [4:0] ip_rd;
  logic ip_flush;
  logic [31:0] op_m_rs1;
  logic [31:0] op_m_rs2;
  logic [2:0] op_m_funct_3;
  logic [31:0] ip_m_result;
  logic ip_m_overflow;
  logic op_rsp_valid;
  logic ip_rsp_ready;
  logic [31:0] op_rsp_result;
  logic op_rsp_overflow;
  logic [4:0] op_rsp_rd;
  logic op_busy;
  modport master (
    output ip_req_valid, ip_rs1, ip_rs2, ip_funct_3, ip_rd, ip_flush, ip_m_result, ip_m_overflow, ip_rsp_ready,
    input op_req_ready, op_m_rs1, op_m_rs2, op_m_funct_3, op_rsp_valid, op_rsp_result, op_rsp_overflow, op_rsp_rd, op_busy
  );
  modport slave (
    input ip_req_valid, ip_rs1, ip_rs2, ip_funct_3, ip_rd, ip_flush, ip_m_result, ip_m_overflow, ip_rsp_ready,
    output op_req_ready, op_m_rs1, op_m_rs2, op_m_funct_3, op_rsp_valid, op_rsp_result, op_rsp_overflow, op_rsp_rd, op_busy
  );
endinterface

// File: rtl/m_ext_ctrl.sv
// m_ext_ctrl: holds operands on m_ext for LATENCY cycles, fast-paths divide corner cases, returns a tagged response
module m_ext_ctrl #(
  parameter int LATENCY = 4
) (
  input logic ip_clk,
  input logic ip_rst,
  m_ext_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  state_t state, state_nx;
  logic [3:0] cnt;
  logic [31:0] rs1, rs2, result, fast_result;
  logic [2:0] funct_3;
  logic [4:0] rd;
  logic overflow, accept, by_zero, fast;
  always_comb begin
    by_zero = bus.ip_rs2 == '0;
    fast = bus.ip_funct_3[2] & (by_zero | (~bus.ip_funct_3[0] & bus.ip_rs1 == 32'h8000_0000 & bus.ip_rs2 == '1));
    fast_result = by_zero ? (bus.ip_funct_3[1] ? bus.ip_rs1 : '1) : (bus.ip_funct_3[1] ? '0 : 32'h8000_0000);
    bus.op_req_ready = ~bus.ip_flush & (state == IDLE | (state == DONE & bus.ip_rsp_ready));
    accept = bus.ip_req_valid & bus.op_req_ready;
    state_nx = bus.ip_flush ? IDLE
             : accept ? (fast ? DONE : EXEC)
             : (state == EXEC & cnt == '0) ? DONE
             : (state == DONE & bus.ip_rsp_ready) ? IDLE
             : state;
  end
  always_ff @(posedge ip_clk) begin
    if (ip_rst) begin
      state <= IDLE;
      cnt <= '0;
      rs1 <= '0;
      rs2 <= '0;
      funct_3 <= '0;
      rd <= '0;
      result <= '0;
      overflow <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        rs1 <= bus.ip_rs1;
        rs2 <= bus.ip_rs2;
        funct_3 <= bus.ip_funct_3;
        rd <= bus.ip_rd;
        cnt <= 4'(LATENCY - 1);
        if (fast) begin
          result <= fast_result;
          overflow <= ~by_zero;
        end
      end else if (state == EXEC) begin
        cnt <= cnt - 1'b1;
        if (cnt == '0) begin
          result <= bus.ip_m_result;
          overflow <= bus.ip_m_overflow;
        end
      end
    end
  end
  assign bus.op_m_rs1 = rs1;
  assign bus.op_m_rs2 = rs2;
  assign bus.op_m_funct_3 = funct_3;
  assign bus.op_rsp_valid = state == DONE;
  assign bus.op_rsp_result = result;
  assign bus.op_rsp_overflow = overflow;
  assign bus.op_rsp_rd = rd;
  assign bus.op_busy = state != IDLE;
endmodule

// File: tb/tb_m_ext_ctrl.sv
// tb_m_ext_ctrl: random and directed stimulus against an RV32M reference model with a queue-based scoreboard
module tb_m_ext_ctrl;
  localparam int LAT = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  m_ext_ctrl_if bus();
  m_ext_ctrl #(.LATENCY(LAT)) dut (.ip_clk(clk), .ip_rst(rst), .bus(bus));
  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0] f3;
    logic [4:0] rd;
    int acc;
    int lat;
  } op_t;
  op_t q[$];
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int age = 0;
  int cur_age;
  logic prev_rst = 1'b1;
  logic [66:0] last_m;
  logic [32:0] m_ref;
  function automatic logic [32:0] ref_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, ub;
    logic [63:0] p;
    int x, y;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ub = {32'b0, b};
    x = a;
    y = b;
    p = '0;
    case (f3)
      3'd0: begin p = sa * sb; return {p[63:32] != {32{p[31]}}, p[31:0]}; end
      3'd1: begin p = sa * sb; return {1'b0, p[63:32]}; end
      3'd2: begin p = sa * ub; return {1'b0, p[63:32]}; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return {1'b0, p[63:32]}; end
      3'd4: return b == 0 ? {1'b0, 32'hFFFF_FFFF} : (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? {1'b1, 32'h8000_0000} : {1'b0, 32'(x / y)};
      3'd5: return b == 0 ? {1'b0, 32'hFFFF_FFFF} : {1'b0, a / b};
      3'd6: return b == 0 ? {1'b0, a} : (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? {1'b1, 32'h0} : {1'b0, 32'(x % y)};
      default: return b == 0 ? {1'b0, a} : {1'b0, a % b};
    endcase
  endfunction
  function automatic bit is_fast(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    return f3 >= 3'd4 && (b == 0 || ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction
  // m_ext stand-in: the result is only correct once operands have been stable for LAT cycles
  always_comb begin
    m_ref = ref_op(bus.op_m_funct_3, bus.op_m_rs1, bus.op_m_rs2);
    cur_age = ({bus.op_m_funct_3, bus.op_m_rs1, bus.op_m_rs2} == last_m) ? age + 1 : 0;
    bus.ip_m_result = cur_age >= LAT - 1 ? m_ref[31:0] : ~m_ref[31:0];
    bus.ip_m_overflow = cur_age >= LAT - 1 ? m_ref[32] : ~m_ref[32];
  end
  always @(posedge clk) begin
    last_m <= {bus.op_m_funct_3, bus.op_m_rs1, bus.op_m_rs2};
    age <= cur_age > 100 ? 100 : cur_age;
    cyc <= cyc + 1;
  end
  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  always @(negedge clk) begin
    op_t e;
    logic [32:0] r;
    logic eb, ev, er;
    if (rst) begin
      q.delete();
      prev_rst = 1'b1;
    end else begin
      if (prev_rst) begin
        chk("reset_busy", 96'(bus.op_busy), 96'd0);
        chk("reset_rsp_valid", 96'(bus.op_rsp_valid), 96'd0);
        chk("reset_m_ops", {bus.op_m_funct_3, bus.op_m_rs1, bus.op_m_rs2}, 96'd0);
        chk("reset_rsp", {bus.op_rsp_overflow, bus.op_rsp_rd, bus.op_rsp_result}, 96'd0);
      end
      prev_rst = 1'b0;
      eb = q.size() != 0;
      ev = 1'b0;
      if (eb) ev = (cyc - q[0].acc) >= q[0].lat;
      er = !bus.ip_flush && (!eb || (ev && bus.ip_rsp_ready));
      chk("busy", 96'(bus.op_busy), 96'(eb));
      chk("rsp_valid", 96'(bus.op_rsp_valid), 96'(ev));
      chk("req_ready", 96'(bus.op_req_ready), 96'(er));
      if (eb) chk("hold_ops", {bus.op_m_funct_3, bus.op_m_rs1, bus.op_m_rs2}, {q[0].f3, q[0].a, q[0].b});
      if (bus.ip_flush) q.delete();
      else begin
        if (ev && bus.ip_rsp_ready) begin
          e = q.pop_front();
          r = ref_op(e.f3, e.a, e.b);
          chk("rsp_result", 96'(bus.op_rsp_result), 96'(r[31:0]));
          chk("rsp_overflow", 96'(bus.op_rsp_overflow), 96'(r[32]));
          chk("rsp_rd", 96'(bus.op_rsp_rd), 96'(e.rd));
        end
        if (bus.ip_req_valid && er) begin
          e.a = bus.ip_rs1;
          e.b = bus.ip_rs2;
          e.f3 = bus.ip_funct_3;
          e.rd = bus.ip_rd;
          e.acc = cyc;
          e.lat = is_fast(e.f3, e.a, e.b) ? 1 : LAT + 1;
          q.push_back(e);
        end
      end
    end
  end
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    bit done;
    done = 1'b0;
    rst = 1'b0;
    bus.ip_flush = 1'b0;
    bus.ip_rsp_ready = 1'b1;
    bus.ip_req_valid = 1'b1;
    bus.ip_funct_3 = f3;
    bus.ip_rs1 = a;
    bus.ip_rs2 = b;
    bus.ip_rd = rd;
    for (int n = 0; n < 40 && !done; n++) begin
      @(negedge clk);
      done = bus.op_req_ready;
      @(posedge clk);
      #1;
    end
    bus.ip_req_valid = 1'b0;
    tests++;
    if (!done) begin
      fails++;
      $display("FAIL issue_timeout: request f3=%0d never accepted", f3);
    end
  endtask
  task automatic idle(input int n);
    rst = 1'b0;
    bus.ip_flush = 1'b0;
    bus.ip_req_valid = 1'b0;
    bus.ip_rsp_ready = 1'b1;
    step(n);
  endtask
  initial begin
    bus.ip_req_valid = 1'b0;
    bus.ip_rs1 = '0;
    bus.ip_rs2 = '0;
    bus.ip_funct_3 = '0;
    bus.ip_rd = '0;
    bus.ip_flush = 1'b0;
    bus.ip_rsp_ready = 1'b1;
    step(3);
    idle(2);
    issue(3'd0, 32'h0001_5C7B, 32'h0000_058A, 5'd5);
    idle(8);
    issue(3'd4, 32'h003A_E27C, 32'h0, 5'd1);
    issue(3'd7, 32'hE3CA_4D08, 32'h0, 5'd2);
    issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd3);
    issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd4);
    idle(3);
    issue(3'd0, 32'h1234_5678, 32'h9ABC_DEF0, 5'd6);
    bus.ip_rsp_ready = 1'b0;
    step(8);
    issue(3'd5, 32'hC748_5D8D, 32'h15A5_1D1A, 5'd7);
    idle(8);
    issue(3'd1, 32'hDEAD_BEEF, 32'h0BAD_F00D, 5'd8);
    step(1);
    bus.ip_flush = 1'b1;
    bus.ip_req_valid = 1'b1;
    step(1);
    idle(3);
    issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9);
    bus.ip_rsp_ready = 1'b0;
    step(6);
    bus.ip_flush = 1'b1;
    step(1);
    idle(3);
    issue(3'd2, 32'h8765_4321, 32'h0000_0007, 5'd10);
    step(2);
    rst = 1'b1;
    step(1);
    idle(2);
    issue(3'd0, 32'h0001_5C7B, 32'h0000_058A, 5'd11);
    idle(8);
    for (int i = 0; i < 3000; i++) begin
      bus.ip_req_valid = $urandom_range(9) < 7;
      bus.ip_funct_3 = 3'($urandom_range(7));
      bus.ip_rs1 = $urandom_range(3) == 0 ? 32'h8000_0000 : $urandom;
      case ($urandom_range(5))
        0: bus.ip_rs2 = 32'h0;
        1: bus.ip_rs2 = 32'hFFFF_FFFF;
        default: bus.ip_rs2 = $urandom;
      endcase
      bus.ip_rd = 5'($urandom);
      bus.ip_rsp_ready = $urandom_range(3) != 0;
      bus.ip_flush = $urandom_range(24) == 0;
      rst = $urandom_range(199) == 0;
      step(1);
    end
    idle(12);
    chk("drain_empty", 96'(q.size()), 96'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/m_ext_ctrl.md
# m_ext_ctrl

Sequencer for the RV32M `m_ext` unit. It sits between the execute stage and `m_ext`:
- accepts one M-extension request through a valid/ready handshake;
- holds the operands stable on the `m_ext` inputs for the unit's fixed compute latency, then captures the result;
- resolves RISC-V divide special cases (divide-by-zero, signed overflow) in one cycle without waiting on `m_ext`;
- presents the result with a destination tag through a valid/ready response handshake, supporting flush.

## Interface
- `LATENCY`, default 4: number of cycles `m_ext` needs from stable operands to a valid `op_result`. Legal range 1..15.

Ports:
- `ip_clk` in 1: clock; all logic on the rising edge.
- `ip_rst` in 1: reset, synchronous, active-high.
- `ip_req_valid` in 1: request present.
- `op_req_ready` out 1: request accepted this cycle when high together with `ip_req_valid`.
- `ip_rs1` in 32: operand 1.
- `ip_rs2` in 32: operand 2.
- `ip_funct_3` in 3: M-extension op, encoded as for `m_ext`: 000 MUL … 111 REMU.
- `ip_rd` in 5: destination tag, returned unchanged.
- `ip_flush` in 1: kill the in-flight or held operation.
- `op_m_rs1` out 32: operand 1 to `m_ext`.
- `op_m_rs2` out 32: operand 2 to `m_ext`.
- `op_m_funct_3` out 3: op to `m_ext`.
- `ip_m_result` in 32: `m_ext` result.
- `ip_m_overflow` in 1: `m_ext` overflow flag.
- `op_rsp_valid` out 1: response present.
- `ip_rsp_ready` in 1: consumer takes the response.
- `op_rsp_result` out 32: result.
- `op_rsp_overflow` out 1: overflow flag.
- `op_rsp_rd` out 5: destination tag.
- `op_busy` out 1: high whenever state ≠ IDLE; used as the pipeline stall.

## Operation
States: IDLE, EXEC, DONE.

**Accept**
- Condition: `ip_req_valid & op_req_ready`.
- `op_req_ready = ~ip_flush & (IDLE | (DONE & ip_rsp_ready))`. This is combinational on `ip_rsp_ready` and `ip_flush`.
- On accept, `ip_rs1`, `ip_rs2`, `ip_funct_3` and `ip_rd` are registered into the hold registers that drive `op_m_*` and the tag.
- Hold registers change only on accept.

**Fast path** (decided at the accept edge from the incoming operands; next state DONE):
- DIV/DIVU with rs2 = 0: result `0xFFFFFFFF`, overflow 0.
- REM/REMU with rs2 = 0: result = rs1, overflow 0.
- DIV with rs1 = `0x80000000`, rs2 = `0xFFFFFFFF`: result `0x80000000`, overflow 1.
- REM with the same operands: result 0, overflow 1.

**Normal path**
- Next state EXEC; the 4-bit counter loads `LATENCY-1`.
- EXEC decrements the counter each cycle.
- At counter = 0, the edge captures `ip_m_result`/`ip_m_overflow` into the response registers; next state DONE.

**DONE**
- `op_rsp_valid` = 1; result, overflow and rd are held stable while `ip_rsp_ready` = 0.
- On `ip_rsp_ready` = 1: if a request is accepted the same cycle, go to EXEC or DONE per that request; otherwise go to IDLE.

**Flush** (priority over everything except reset)
- EXEC or DONE → IDLE; the response is dropped and `op_rsp_valid` is 0 the next cycle.
- In IDLE it is a no-op.
- No accept occurs in a flush cycle.

**Reset** (any state, including mid-EXEC)
- Next state IDLE; counter 0.
- All outputs 0: `op_req_ready` follows the formula, giving 1 after reset when `ip_flush` = 0.

## Timing
- Accept at edge T; `op_m_*` valid from cycle T+1.
- Normal path: EXEC occupies cycles T+1..T+LATENCY; `op_rsp_valid` rises in cycle T+LATENCY+1. Latency is LATENCY+1 (5 at default).
- Fast path: `op_rsp_valid` in cycle T+1; latency 1.
- Throughput: with `ip_rsp_ready` held high, one request per LATENCY+1 cycles (normal) or per cycle (fast).
- `op_rsp_*` are registered outputs; `op_busy` is registered state decode.
- `m_ext` result is sampled exactly once, at the last EXEC edge. `ip_m_result` is ignored at all other times.

## Test plan
- **MUL, normal path.** `LATENCY`=4; MUL `0x00015C7B`×`0x0000058A`, rd=5, accepted at T; model returns `0x078A414E` → `op_rsp_valid` at T+5, result `0x078A414E`, rd 5, overflow 0; `op_m_*` stable T+1..T+4.
- **DIV by zero, fast path.** DIV `0x003AE27C`/0 → `op_rsp_valid` at T+1, result `0xFFFFFFFF`, overflow 0; then REMU `0xE3CA4D08`/0 → result `0xE3CA4D08`.
- **Signed overflow, fast path.** DIV `0x80000000`/`0xFFFFFFFF` → T+1, result `0x80000000`, overflow 1; REM with the same operands → result 0, overflow 1.
- **Backpressure and back-to-back.** Hold `ip_rsp_ready`=0 for 3 cycles in DONE → result/rd/overflow stable, `op_req_ready`=0; raise `ip_rsp_ready` with a new DIVU `0xC7485D8D`/`0x15A51D1A` pending → accepted that same cycle, new response 5 cycles later.
- **Flush.** Flush in the 2nd EXEC cycle with `ip_req_valid`=1 → no response, `op_req_ready`=0 in the flush cycle, IDLE and ready next cycle; flush in DONE → `op_rsp_valid` 0 next cycle.
- **Reset mid-operation.** `ip_rst` in EXEC → next cycle IDLE, all outputs 0, `op_busy` 0; the following MUL completes with normal latency.
